// File: rtl/serial_adder_sched.sv
// Bit-serial adder scheduler: two requesters share one external 1-bit full-adder cell.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow flag on the response.
module serial_adder_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             rsp_ovf,
`endif
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_sumout,
    input  logic             add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_id;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic w_idle;
    logic w_run;
    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;

    // r_last remembers the previous winner; a tie goes to the other one.
    assign w_grant0 = req0_valid & (~req1_valid | r_last);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

    // Gate with rst so nothing handshakes or toggles while reset is held.
    assign w_idle = (r_state == S_IDLE) & ~rst;
    assign w_run  = (r_state == S_RUN) & ~rst;

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    // Operands shift right, so bit 0 is always the bit of the current cycle.
    assign add_a   = w_run & r_a[0];
    assign add_b   = w_run & r_b[0];
    assign add_cin = w_run & r_carry;

    assign rsp_valid = (r_state == S_DONE) & ~rst;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_carry;
    assign rsp_id    = r_id;
`ifdef SERIAL_ADDER_OVF_EN
    assign rsp_ovf   = r_ovf;
`endif

    // Scheduler FSM: accept, stream one bit per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_id    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc0 | w_acc1) begin
                        r_a     <= w_acc1 ? req1_a : req0_a;
                        r_b     <= w_acc1 ? req1_b : req0_b;
                        r_carry <= w_acc1 ? req1_cin : req0_cin;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_id    <= w_acc1;
                        r_last  <= w_acc1;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_cnt] <= add_sumout;
                    r_carry      <= add_cout;
                    r_a          <= r_a >> 1;
                    r_b          <= r_b >> 1;
                    r_cnt        <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
                        // add_cin here is the carry into the MSB.
                        r_ovf   <= add_cin ^ add_cout;
`endif
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
